// File: rtl/gpio_irq_ip_if.sv
// Register-bus interface for gpio_irq_ip: one access per gpio_en cycle,
// read data returned one cycle later qualified by gpio_rvalid.
interface gpio_irq_ip_if;
  logic        gpio_en;
  logic        write_enable;
  logic [31:0] gpio_addr;
  logic [31:0] gpio_wdata;
  logic [31:0] gpio_rdata;
  logic        gpio_rvalid;

  modport master (
    output gpio_en, write_enable, gpio_addr, gpio_wdata,
    input  gpio_rdata, gpio_rvalid
  );

  modport slave (
    input  gpio_en, write_enable, gpio_addr, gpio_wdata,
    output gpio_rdata, gpio_rvalid
  );
endinterface

// File: rtl/gpio_irq_ip.sv
// GPIO block with per-pin direction, synchronized inputs and sticky edge interrupts.
// Register reads return one cycle after the strobe; no backpressure, every strobe is accepted.
module gpio_irq_ip #(
  parameter int          N_PINS      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpio_irq_ip_if.slave      bus,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  output logic              irq
);

  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_DIR    = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADDR_READ   = BASE_ADDR + 32'h08;
  localparam logic [31:0] ADDR_SET    = BASE_ADDR + 32'h0C;
  localparam logic [31:0] ADDR_CLR    = BASE_ADDR + 32'h10;
  localparam logic [31:0] ADDR_RISE   = BASE_ADDR + 32'h14;
  localparam logic [31:0] ADDR_FALL   = BASE_ADDR + 32'h18;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h1C;
  localparam logic [2:0]  WARM_LAST   = 3'(SYNC_STAGES + 1);

  logic [N_PINS-1:0] data_q, data_d;
  logic [N_PINS-1:0] dir_q, dir_d;
  logic [N_PINS-1:0] rise_q, rise_d;
  logic [N_PINS-1:0] fall_q, fall_d;
  logic [N_PINS-1:0] status_q, status_d;
  logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;
  logic [N_PINS-1:0] prev_q;
  logic [2:0]        warm_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q;

  logic [N_PINS-1:0] sync_in, wdat, read_val, events, w1c_mask;
  logic [31:0]       rd_mux;
  logic              wr, rd;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign wr      = bus.gpio_en & bus.write_enable;
  assign rd      = bus.gpio_en & ~bus.write_enable;
  assign wdat    = bus.gpio_wdata[N_PINS-1:0];

  always_comb begin
    read_val = (data_q & dir_q) | (sync_in & ~dir_q);
    rd_mux   = '0;
    case (bus.gpio_addr)
      ADDR_DATA:   rd_mux[N_PINS-1:0] = data_q;
      ADDR_DIR:    rd_mux[N_PINS-1:0] = dir_q;
      ADDR_READ:   rd_mux[N_PINS-1:0] = read_val;
      ADDR_RISE:   rd_mux[N_PINS-1:0] = rise_q;
      ADDR_FALL:   rd_mux[N_PINS-1:0] = fall_q;
      ADDR_STATUS: rd_mux[N_PINS-1:0] = status_q;
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    w1c_mask = '0;
    if (wr) begin
      case (bus.gpio_addr)
        ADDR_DATA:   data_d   = wdat;
        ADDR_DIR:    dir_d    = wdat;
        ADDR_SET:    data_d   = data_q | wdat;
        ADDR_CLR:    data_d   = data_q & ~wdat;
        ADDR_RISE:   rise_d   = wdat;
        ADDR_FALL:   fall_d   = wdat;
        ADDR_STATUS: w1c_mask = wdat;
        default:     data_d   = data_q;
      endcase
    end
    // Events are masked until the sync chain and prev_in hold real pin levels.
    events = '0;
    if (warm_q == WARM_LAST) begin
      events = ((sync_in & ~prev_q & rise_q) | (~sync_in & prev_q & fall_q)) & ~dir_q;
    end
    status_d = (status_q & ~w1c_mask) | events;
    rdata_d  = rd ? rd_mux : rdata_q;
    rvalid_d = rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      dir_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      status_q  <= status_d;
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q   <= sync_in;
      if (warm_q != WARM_LAST) begin
        warm_q <= warm_q + 3'd1;
      end
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= |status_q;
    end
  end

  assign bus.gpio_rdata  = rdata_q;
  assign bus.gpio_rvalid = rvalid_q;
  assign pin_out         = data_q;
  assign pin_oe          = rst ? '0 : dir_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_gpio_irq_ip.sv
// Bench for gpio_irq_ip: a 32-pin and an 8-pin instance sharing clock and reset.
module tb_gpio_irq_ip;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] O_DATA = 32'h00, O_DIR = 32'h04, O_READ = 32'h08, O_SET = 32'h0C;
  localparam logic [31:0] O_CLR = 32'h10, O_RISE = 32'h14, O_FALL = 32'h18, O_STAT = 32'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pin_a = '0, pout_a, poe_a;
  logic [7:0]  pin_b = '0, pout_b, poe_b;
  logic        irq_a, irq_b;
  int          total = 0;
  int          bad = 0;

  gpio_irq_ip_if bus_a ();
  gpio_irq_ip_if bus_b ();

  gpio_irq_ip #(.N_PINS(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .pin_in(pin_a), .pin_out(pout_a), .pin_oe(poe_a), .irq(irq_a)
  );
  gpio_irq_ip #(.N_PINS(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .pin_in(pin_b), .pin_out(pout_b), .pin_oe(poe_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit nb, input logic [31:0] off, input logic [31:0] d);
    if (nb) begin
      bus_b.gpio_en = 1'b1; bus_b.write_enable = 1'b1; bus_b.gpio_addr = BASE + off; bus_b.gpio_wdata = d;
    end else begin
      bus_a.gpio_en = 1'b1; bus_a.write_enable = 1'b1; bus_a.gpio_addr = BASE + off; bus_a.gpio_wdata = d;
    end
    cyc(1);
    bus_a.gpio_en = 1'b0;
    bus_b.gpio_en = 1'b0;
  endtask

  task automatic rd(input bit nb, input logic [31:0] off, output logic [31:0] d, output logic v);
    if (nb) begin
      bus_b.gpio_en = 1'b1; bus_b.write_enable = 1'b0; bus_b.gpio_addr = BASE + off;
    end else begin
      bus_a.gpio_en = 1'b1; bus_a.write_enable = 1'b0; bus_a.gpio_addr = BASE + off;
    end
    cyc(1);
    bus_a.gpio_en = 1'b0;
    bus_b.gpio_en = 1'b0;
    d = nb ? bus_b.gpio_rdata : bus_a.gpio_rdata;
    v = nb ? bus_b.gpio_rvalid : bus_a.gpio_rvalid;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic v;
    total++; if (bus_a.gpio_rvalid !== 1'b0 || bus_a.gpio_rdata !== 32'h0) begin bad++;
      $display("FAIL reset_bus rvalid=%b rdata=%h want 0/0", bus_a.gpio_rvalid, bus_a.gpio_rdata); end
    total++; if (irq_a !== 1'b0 || poe_a !== 32'h0 || pout_a !== 32'h0) begin bad++;
      $display("FAIL reset_pins irq=%b oe=%h out=%h want zeros", irq_a, poe_a, pout_a); end
    rst = 1'b0;
    rd(0, O_DATA, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++;
      $display("FAIL reset_data v=%b d=%h want 1/0", v, d); end
    wr(0, O_DIR, 32'h0000_00FF);
    total++; if (poe_a !== 32'h0000_00FF) begin bad++;
      $display("FAIL oe_pre_reset got %h want 000000ff", poe_a); end
    // Reset arrives together with a read strobe: reset wins.
    rst = 1'b1;
    bus_a.gpio_en = 1'b1; bus_a.write_enable = 1'b0; bus_a.gpio_addr = BASE + O_DIR;
    #1;
    total++; if (poe_a !== 32'h0) begin bad++;
      $display("FAIL oe_during_reset got %h want 0", poe_a); end
    cyc(1);
    bus_a.gpio_en = 1'b0;
    total++; if (bus_a.gpio_rvalid !== 1'b0) begin bad++;
      $display("FAIL reset_read_rvalid got %b want 0", bus_a.gpio_rvalid); end
    rst = 1'b0;
    rd(0, O_DIR, d, v);
    total++; if (d !== 32'h0) begin bad++;
      $display("FAIL reset_dir got %h want 0", d); end
  endtask

  task automatic test_dir_read;
    logic [31:0] d, exp;
    logic v;
    wr(0, O_DIR, 32'hAAAA_AAAA);
    wr(0, O_DATA, 32'hDEAD_BEEF);
    pin_a = 32'hCAFE_BABE;
    cyc(3);
    exp = (32'hDEAD_BEEF & 32'hAAAA_AAAA) | (32'hCAFE_BABE & ~32'hAAAA_AAAA);
    rd(0, O_READ, d, v);
    total++; if (v !== 1'b1 || d !== exp) begin bad++;
      $display("FAIL dir_read v=%b d=%h want 1/%h", v, d, exp); end
    total++; if (poe_a !== 32'hAAAA_AAAA || pout_a !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL dir_pins oe=%h out=%h want aaaaaaaa/deadbeef", poe_a, pout_a); end
    cyc(1);
    total++; if (bus_a.gpio_rvalid !== 1'b0 || bus_a.gpio_rdata !== exp) begin bad++;
      $display("FAIL rvalid_pulse v=%b d=%h want 0/%h", bus_a.gpio_rvalid, bus_a.gpio_rdata, exp); end
  endtask

  task automatic test_set_clr;
    logic [31:0] d;
    logic v;
    wr(0, O_DATA, 32'h0000_FF00);
    wr(0, O_SET, 32'h0000_000F);
    wr(0, O_CLR, 32'h0000_0F00);
    rd(0, O_DATA, d, v);
    total++; if (d !== 32'h0000_F00F || pout_a !== 32'h0000_F00F) begin bad++;
      $display("FAIL set_clr d=%h out=%h want 0000f00f", d, pout_a); end
    rd(0, O_SET, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL set_reads0 got %h want 0", d); end
    rd(0, O_CLR, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_reads0 got %h want 0", d); end
  endtask

  task automatic test_edge_irq;
    logic [31:0] d;
    logic v;
    wr(0, O_DIR, 32'h0); wr(0, O_RISE, 32'h0); wr(0, O_FALL, 32'h0);
    pin_a = 32'h2;
    cyc(5);
    wr(0, O_STAT, 32'hFFFF_FFFF);
    wr(0, O_RISE, 32'h1);
    wr(0, O_FALL, 32'h2);
    pin_a = 32'h1;
    cyc(3);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_early got %b want 0", irq_a); end
    cyc(1);
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_rise got %b want 1", irq_a); end
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL status_both got %h want 3", d); end
    wr(0, O_STAT, 32'h1);
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h2 || irq_a !== 1'b1) begin bad++;
      $display("FAIL w1c d=%h irq=%b want 2/1", d, irq_a); end
    wr(0, O_RISE, 32'h0); wr(0, O_FALL, 32'h0);
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL en_clear_keeps got %h want 2", d); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic v;
    pin_a = 32'h0;
    cyc(4);
    wr(0, O_RISE, 32'h1);
    wr(0, O_STAT, 32'hFFFF_FFFF);
    pin_a = 32'h1;
    cyc(2);
    wr(0, O_STAT, 32'h1);
    rd(0, O_STAT, d, v);
    total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL collision got %h want bit0=1", d); end
    wr(0, O_STAT, 32'h1);
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h0 || irq_a !== 1'b0) begin bad++;
      $display("FAIL collision_clear d=%h irq=%b want 0/0", d, irq_a); end
  endtask

  task automatic test_warmup;
    logic [31:0] d;
    logic v;
    pin_a = 32'hFFFF_FFFF;
    pin_b = 8'hFF;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    wr(0, O_RISE, 32'hFFFF_FFFF);
    cyc(8);
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL warm_irq got %b want 0", irq_a); end
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL warm_status got %h want 0", d); end
    pin_a = ~32'h20;
    cyc(4);
    pin_a = 32'hFFFF_FFFF;
    cyc(4);
    rd(0, O_STAT, d, v);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL post_warm_edge got %h want 20", d); end
  endtask

  task automatic test_narrow;
    logic [31:0] d;
    logic v;
    wr(1, O_DATA, 32'hFFFF_FFFF);
    rd(1, O_DATA, d, v);
    total++; if (d !== 32'h0000_00FF || pout_b !== 8'hFF) begin bad++;
      $display("FAIL narrow_data d=%h out=%h want 000000ff/ff", d, pout_b); end
    wr(1, 32'h20, 32'h1234_5678);
    rd(1, 32'h20, d, v);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++;
      $display("FAIL unmapped v=%b d=%h want 1/0", v, d); end
    rd(1, O_DIR, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_dir got %h want 0", d); end
    rd(1, O_DATA, d, v);
    total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL unmapped_data got %h want ff", d); end
    wr(0, O_DIR, 32'h0000_1234);
    wr(0, 32'h06, 32'hFFFF_FFFF);
    rd(0, 32'h06, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL misaligned_read got %h want 0", d); end
    rd(0, O_DIR, d, v);
    total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL misaligned_write got %h want 1234", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3];
    logic [31:0] offs [3];
    exp[0] = 32'h1111_1111; exp[1] = 32'h2222_2222; exp[2] = 32'h3333_3333;
    offs[0] = O_DATA; offs[1] = O_DIR; offs[2] = O_FALL;
    for (int i = 0; i < 3; i++) wr(0, offs[i], exp[i]);
    bus_a.write_enable = 1'b0;
    bus_a.gpio_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.gpio_addr = BASE + offs[i];
      cyc(1);
      if (i == 2) bus_a.gpio_en = 1'b0;
      total++; if (bus_a.gpio_rvalid !== 1'b1 || bus_a.gpio_rdata !== exp[i]) begin bad++;
        $display("FAIL b2b_%0d v=%b d=%h want 1/%h", i, bus_a.gpio_rvalid, bus_a.gpio_rdata, exp[i]); end
    end
    cyc(1);
    total++; if (bus_a.gpio_rvalid !== 1'b0 || bus_a.gpio_rdata !== exp[2]) begin bad++;
      $display("FAIL b2b_hold v=%b d=%h want 0/%h", bus_a.gpio_rvalid, bus_a.gpio_rdata, exp[2]); end
    wr(0, O_FALL, 32'h0);
  endtask

  task automatic test_random_io;
    logic [31:0] m_data, m_dir, val, d;
    logic v;
    m_data = $urandom; m_dir = $urandom;
    wr(0, O_DATA, m_data);
    wr(0, O_DIR, m_dir);
    for (int i = 0; i < 16; i++) begin
      val = $urandom;
      case ($urandom_range(0, 3))
        0: begin wr(0, O_DATA, val); m_data = val; end
        1: begin wr(0, O_DIR, val); m_dir = val; end
        2: begin wr(0, O_SET, val); m_data = m_data | val; end
        default: begin wr(0, O_CLR, val); m_data = m_data & ~val; end
      endcase
      pin_a = $urandom;
      cyc(3);
      rd(0, O_READ, d, v);
      total++; if (d !== ((m_data & m_dir) | (pin_a & ~m_dir))) begin bad++;
        $display("FAIL rand_read_%0d got %h want %h", i, d, (m_data & m_dir) | (pin_a & ~m_dir)); end
      total++; if (pout_a !== m_data || poe_a !== m_dir) begin bad++;
        $display("FAIL rand_pins_%0d out=%h oe=%h want %h/%h", i, pout_a, poe_a, m_data, m_dir); end
    end
  endtask

  task automatic test_random_edges;
    logic [31:0] rise, fall, old, nw, exp, d;
    logic v;
    wr(0, O_DIR, 32'h0);
    pin_a = $urandom;
    cyc(4);
    rise = $urandom; fall = $urandom;
    wr(0, O_RISE, rise);
    wr(0, O_FALL, fall);
    wr(0, O_STAT, 32'hFFFF_FFFF);
    exp = 32'h0;
    for (int i = 0; i < 8; i++) begin
      old = pin_a;
      nw = $urandom;
      pin_a = nw;
      exp = exp | (rise & nw & ~old) | (fall & ~nw & old);
      cyc(4);
      rd(0, O_STAT, d, v);
      total++; if (d !== exp || irq_a !== (exp != 0)) begin bad++;
        $display("FAIL rand_edge_%0d status=%h irq=%b want %h/%b", i, d, irq_a, exp, exp != 0); end
    end
  endtask

  initial begin
    bus_a.gpio_en = 1'b0; bus_a.write_enable = 1'b0; bus_a.gpio_addr = '0; bus_a.gpio_wdata = '0;
    bus_b.gpio_en = 1'b0; bus_b.write_enable = 1'b0; bus_b.gpio_addr = '0; bus_b.gpio_wdata = '0;
    cyc(3);
    test_reset();
    test_dir_read();
    test_set_clr();
    test_edge_irq();
    test_collision();
    test_warmup();
    test_narrow();
    test_back_to_back();
    test_random_io();
    test_random_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
